mem_wrapper_access_arbiter: RTL

Two-requester arbiter that shares the memory wrapper access path between the information-block controller ("info") and the main-array controller ("main"). It sits in front of the wrapper access mux. It drives the mux selector and gates each requester's `op_valid` so only the granted requester reaches the memory. A grant is held until the memory returns `i_valid` or a timeout expires. Fairness between the two requesters is round-robin.

---
 rtl/mem_wrapper_access_arbiter.sv | 71 +++++++
 1 files changed

// File: rtl/mem_wrapper_access_arbiter.sv
// mem_wrapper_access_arbiter: round-robin info/main arbiter for the memory wrapper access path.
// Grant timeout/abort logic is built only when MEM_WRAPPER_ARB_TIMEOUT_EN is defined.
module mem_wrapper_access_arbiter #(
    parameter int NBW_TMO        = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_info_op_valid,
    input  logic i_main_op_valid,
    input  logic i_valid,
    output logic o_info_op_valid,
    output logic o_main_op_valid,
    output logic o_selector,
    output logic o_info_grant,
    output logic o_main_grant,
    output logic o_busy,
    output logic o_timeout,
    output logic o_timeout_main
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT_INFO = 2'd1, GNT_MAIN = 2'd2} state_t;
    state_t state;
    logic   last_main;
    logic   abort;
    logic   pick_main;
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << NBW_TMO)) begin : g_bad_cfg
        $error("mem_wrapper_access_arbiter: TIMEOUT_CYCLES out of range for NBW_TMO");
    end
    // On a tie, the requester not served last wins
    assign pick_main = i_main_op_valid & (~i_info_op_valid | ~last_main);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            o_selector <= 1'b0;
            last_main  <= 1'b1;
        end else if (state == IDLE) begin
            if (i_info_op_valid | i_main_op_valid) begin
                state      <= pick_main ? GNT_MAIN : GNT_INFO;
                o_selector <= pick_main;
                last_main  <= pick_main;
            end
        end else if (i_valid | abort) begin
            state <= IDLE;
        end
    end
`ifdef MEM_WRAPPER_ARB_TIMEOUT_EN
    logic [NBW_TMO-1:0] tmo_cnt;
    // Completion on the terminal-count cycle wins over abort
    assign abort = (state != IDLE) && !i_valid && (tmo_cnt == NBW_TMO'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt        <= '0;
            o_timeout      <= 1'b0;
            o_timeout_main <= 1'b0;
        end else begin
            tmo_cnt   <= (state == IDLE) ? '0 : tmo_cnt + 1'b1;
            o_timeout <= abort;
            if (abort) o_timeout_main <= (state == GNT_MAIN);
        end
    end
`else
    assign abort          = 1'b0;
    assign o_timeout      = 1'b0;
    assign o_timeout_main = 1'b0;
`endif
    assign o_info_grant    = (state == GNT_INFO);
    assign o_main_grant    = (state == GNT_MAIN);
    assign o_busy          = (state != IDLE);
    assign o_info_op_valid = i_info_op_valid & o_info_grant;
    assign o_main_op_valid = i_main_op_valid & o_main_grant;
endmodule
